// File: rtl/ifm_tile_scheduler_if.sv
// Downstream bus from ifm_tile_scheduler to the img2col_ifm / ifm_buffer pair.
// master = scheduler side, slave = img2col/buffer side.
interface ifm_tile_scheduler_if #(
  parameter int ADDR_W = 10,
  parameter int DIM_W  = 6
);
  logic              buf_empty;
  logic              i2c_ready;
  logic              i2c_ifm_start;
  logic [ADDR_W-1:0] base_addr;
  logic              addr_valid;
  logic [3:0]        ksize;
  logic [DIM_W-1:0]  tile_length;
  logic [DIM_W-1:0]  tile_height;

  modport master (
    input  buf_empty, i2c_ready,
    output i2c_ifm_start, base_addr, addr_valid, ksize, tile_length, tile_height
  );

  modport slave (
    output buf_empty, i2c_ready,
    input  i2c_ifm_start, base_addr, addr_valid, ksize, tile_length, tile_height
  );
endinterface

// File: rtl/ifm_tile_scheduler.sv
// Walks overlapping img2col tiles across an ifm in raster order, one start pulse per tile.
// Optional watchdog on the img2col busy/ready cycle: define IFM_SCHED_TIMEOUT_EN.
module ifm_tile_scheduler #(
  parameter int ADDR_W      = 10,
  parameter int DIM_W       = 6,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [DIM_W-1:0]  cfg_ifm_width,
  input  logic [DIM_W-1:0]  cfg_ifm_height,
  input  logic [DIM_W-1:0]  cfg_tile_length,
  input  logic [DIM_W-1:0]  cfg_tile_height,
  input  logic [3:0]        cfg_ksize,
  ifm_tile_scheduler_if.master dn,
  output logic              busy,
  output logic [7:0]        tile_cnt,
  output logic              done,
  output logic              err
);

  localparam int OW = DIM_W + 1;
  localparam int PW = 2 * DIM_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BUF,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    NEXT,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] base_q;
  logic [DIM_W-1:0]  ifm_w_q, ifm_h_q;
  logic [OW-1:0]     col_off, row_off;
  logic [OW-1:0]     h_step, v_step, col_lim, row_lim, col_step, row_step;
  logic [OW-1:0]     col_nxt, row_nxt;
  logic [PW-1:0]     row_prod;
  logic [ADDR_W-1:0] tile_addr;
  logic              row_fin, row_last, last_tile;
  logic              cfg_bad;
  logic              timeout_hit;

  assign cfg_bad = (cfg_ksize == 4'd0)
                || (OW'(cfg_ksize) > OW'(cfg_tile_length))
                || (OW'(cfg_ksize) > OW'(cfg_tile_height))
                || (cfg_tile_length > cfg_ifm_width)
                || (cfg_tile_height > cfg_ifm_height);

  // Tile stepping; the final tile of a row/column is clamped flush to the ifm edge.
  assign h_step    = OW'(dn.tile_length) - OW'(dn.ksize) + OW'(1);
  assign v_step    = OW'(dn.tile_height) - OW'(dn.ksize) + OW'(1);
  assign col_lim   = OW'(ifm_w_q) - OW'(dn.tile_length);
  assign row_lim   = OW'(ifm_h_q) - OW'(dn.tile_height);
  assign col_step  = col_off + h_step;
  assign row_step  = row_off + v_step;
  assign row_fin   = (col_off + OW'(dn.tile_length)) == OW'(ifm_w_q);
  assign row_last  = (row_off + OW'(dn.tile_height)) == OW'(ifm_h_q);
  assign last_tile = row_fin && row_last;
  assign col_nxt   = row_fin ? '0 : ((col_step < col_lim) ? col_step : col_lim);
  assign row_nxt   = row_fin ? ((row_step < row_lim) ? row_step : row_lim) : row_off;

  assign row_prod  = PW'(row_off) * PW'(ifm_w_q);
  assign tile_addr = base_q + ADDR_W'(row_prod) + ADDR_W'(col_off);

  always_ff @(posedge clock) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (cfg_start && !cfg_bad) state_nxt = WAIT_BUF;
      WAIT_BUF:  if (dn.buf_empty) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (!dn.i2c_ready) state_nxt = WAIT_DONE;
      WAIT_DONE: if (dn.i2c_ready) state_nxt = NEXT;
      NEXT:      state_nxt = last_tile ? DONE : WAIT_BUF;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (timeout_hit) state_nxt = IDLE;
  end

  always_comb begin
    busy          = (state != IDLE);
    done          = (state == DONE);
    dn.addr_valid = (state == ISSUE) || (state == WAIT_BUSY) || (state == WAIT_DONE);
  end

`ifdef IFM_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;
  logic            in_wait;

  assign in_wait     = (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign timeout_hit = in_wait && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock) begin
    if (rst)                               to_cnt <= '0;
    else if (!in_wait || state_nxt != state) to_cnt <= '0;
    else                                   to_cnt <= to_cnt + 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC > 0);
  assign timeout_hit    = 1'b0;
`endif

  // The start pulse is registered off ISSUE so img2col sees a stable base_addr first.
  always_ff @(posedge clock) begin
    if (rst) begin
      dn.i2c_ifm_start <= 1'b0;
      dn.base_addr     <= '0;
      dn.ksize         <= '0;
      dn.tile_length   <= '0;
      dn.tile_height   <= '0;
      base_q           <= '0;
      ifm_w_q          <= '0;
      ifm_h_q          <= '0;
      col_off          <= '0;
      row_off          <= '0;
      tile_cnt         <= '0;
      err              <= 1'b0;
    end else begin
      dn.i2c_ifm_start <= (state == ISSUE);
      err              <= timeout_hit;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            base_q         <= cfg_base_addr;
            ifm_w_q        <= cfg_ifm_width;
            ifm_h_q        <= cfg_ifm_height;
            dn.tile_length <= cfg_tile_length;
            dn.tile_height <= cfg_tile_height;
            dn.ksize       <= cfg_ksize;
            if (cfg_bad) begin
              err <= 1'b1;
            end else begin
              col_off  <= '0;
              row_off  <= '0;
              tile_cnt <= '0;
            end
          end
        end
        WAIT_BUF: begin
          if (dn.buf_empty) dn.base_addr <= tile_addr;
        end
        WAIT_DONE: begin
          if (dn.i2c_ready && !timeout_hit && tile_cnt != 8'hFF) tile_cnt <= tile_cnt + 8'd1;
        end
        NEXT: begin
          col_off <= col_nxt;
          row_off <= row_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ifm_tile_scheduler.md
Name: ifm_tile_scheduler

Overview:
- Sequences img2col_ifm across a full input feature map that is larger than one tile.
- Walks overlapping tiles in raster order; for each tile it waits for ifm_buffer to drain (buf_empty), computes the tile base address, pulses i2c_ifm_start, and tracks img2col through its busy/ready cycle.
- Sits between the layer-level controller and the img2col_ifm / ifm_buffer pair, and holds tile configuration stable while each tile is being processed.

Parameters:
- ADDR_W, 10, IFM BRAM address width; base_addr arithmetic wraps modulo 2^ADDR_W.
- DIM_W, 6, width of all dimension fields.
- TIMEOUT_CYC, 4096, watchdog limit in cycles; used only with the optional feature.

Ports:
- clock  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cfg_start  in  1  one-cycle pulse; latches all cfg_* inputs and starts a layer
- cfg_base_addr  in  ADDR_W  BRAM address of ifm pixel (0,0)
- cfg_ifm_width  in  DIM_W  ifm width in pixels
- cfg_ifm_height  in  DIM_W  ifm height in pixels
- cfg_tile_length  in  DIM_W  tile width
- cfg_tile_height  in  DIM_W  tile height
- cfg_ksize  in  4  kernel size
- buf_empty  in  1  from ifm_buffer
- i2c_ready  in  1  from img2col_ifm; high when idle
- i2c_ifm_start  out  1  one-cycle start pulse to img2col_ifm
- base_addr  out  ADDR_W  tile base address; valid while addr_valid is high
- addr_valid  out  1  high from ISSUE until that tile completes
- ksize  out  4  latched cfg_ksize
- tile_length  out  DIM_W  latched cfg_tile_length
- tile_height  out  DIM_W  latched cfg_tile_height
- busy  out  1  high in any state except IDLE
- tile_cnt  out  8  number of tiles completed in the current layer
- done  out  1  one-cycle pulse after the last tile completes
- err  out  1  one-cycle pulse on a configuration error or timeout

Behaviour:
- Reset values: all outputs 0; state IDLE; column and row offsets 0.
- Step sizes: h_step = tile_length - ksize + 1; v_step = tile_height - ksize + 1.
- Tile address: base_addr = cfg_base_addr + row_off*ifm_width + col_off, truncated to ADDR_W.
- State IDLE: on cfg_start, latch config and check it. The config is invalid if any of the following holds:
  - ksize == 0
  - ksize > tile_length or ksize > tile_height
  - tile_length > ifm_width or tile_height > ifm_height
  - If invalid: pulse err next cycle and stay in IDLE.
  - If valid: go to WAIT_BUF with col_off = row_off = 0 and tile_cnt = 0.
- State WAIT_BUF: when buf_empty == 1, register base_addr and go to ISSUE.
- State ISSUE: drive i2c_ifm_start = 1 and addr_valid = 1 for exactly one cycle, then go to WAIT_BUSY. The start pulse occurs 2 cycles after buf_empty is sampled high.
- State WAIT_BUSY: wait for i2c_ready == 0, then go to WAIT_DONE. If i2c_ready is already 0 in the first cycle, the transition happens immediately.
- State WAIT_DONE: when i2c_ready == 1, increment tile_cnt, drop addr_valid, and go to NEXT.
- State NEXT: advance the tile position.
  - Column: if col_off + tile_length == ifm_width, the row is finished; otherwise col_off = min(col_off + h_step, ifm_width - tile_length), clamping the last tile to the right edge.
  - Row finished: apply the same rule to row_off using v_step and ifm_height, and reset col_off to 0.
  - If the row is finished and row_off + tile_height == ifm_height, go to DONE; otherwise go to WAIT_BUF.
- State DONE: pulse done for one cycle, then go to IDLE. tile_cnt holds its value until the next cfg_start.
- cfg_start is ignored while busy.
- tile_cnt saturates at 255.
- Offset arithmetic is computed at DIM_W+1 bits so min() and compare operations cannot overflow.
- Reset asserted mid-operation: state goes to IDLE on the next clock edge; any in-flight pulse is suppressed; addr_valid returns to 0.
- If buf_empty and the end of the WAIT_DONE condition arrive in the same cycle, WAIT_DONE is processed first; buf_empty is resampled in WAIT_BUF.

Optional Feature:
- Macro: IFM_SCHED_TIMEOUT_EN.
- Defined: a counter runs in WAIT_BUSY and WAIT_DONE and clears on every state change. When it reaches TIMEOUT_CYC, the block pulses err, drops addr_valid, goes to IDLE, and does not pulse done.
- Undefined: no counter; the block waits indefinitely; err is raised only for configuration errors.

Test Plan:
- Single tile: base 14, ifm 28x28, tile 28x28, ksize 3; i2c_ready drops 3 cycles after start and rises 40 cycles later -> one start pulse, base_addr = 14, tile_cnt = 1, done pulses once.
- Horizontal split with edge clamp: base 0, ifm 56 wide x 28 tall, tile 28x28, ksize 3 -> three starts with base_addr 0, 26, 28; tile_cnt = 3.
- 2-D walk: base 0, ifm 40x40, tile 28x28, ksize 3 -> four starts with base_addr 0, 12, 480, 492 (row_off 12 × 40 = 480).
- Gating: hold buf_empty = 0 for 100 cycles after a tile completes -> no start pulse; the start pulse comes 2 cycles after buf_empty rises.
- Bad config: tile_length = 30 with ifm_width = 28 -> err pulse, busy stays 0, no start pulse. Separately, assert rst during WAIT_DONE -> all outputs are 0 on the next cycle.
- With IFM_SCHED_TIMEOUT_EN and TIMEOUT_CYC = 64: hold i2c_ready = 0 -> err pulses 64 cycles after entering WAIT_BUSY, and done never pulses.
